// File: rtl/n64_flashram_executor.sv
// FlashRAM back-end executor: runs a latched page-write or erase against
// save memory over a word-wide request/ack port.
//
// Ports:
//   clk, reset              - system clock, synchronous active-high reset
//   enable                  - emulation enabled; when low an op completes
//                             without touching memory
//   operation_pending       - an op is queued by the front-end
//   write_or_erase          - 1 = erase, 0 = page write
//   sector_or_all           - erase scope: 1 = whole chip, 0 = one sector
//   sector                  - page number (write) / sector select (erase)
//   operation_done          - one-cycle completion pulse
//   buf_address, buf_rdata  - page-buffer read port (1-cycle read latency)
//   mem_request, mem_ack    - memory write handshake
//   mem_address, mem_wdata  - memory write address/data
`timescale 1ns/1ps
module n64_flashram_executor #(
    parameter int                MEM_AW     = 24,
    parameter logic [MEM_AW-1:0] FLASH_BASE = 24'h0FC000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              operation_pending,
    input  logic              write_or_erase,
    input  logic              sector_or_all,
    input  logic [9:0]        sector,
    output logic              operation_done,
    output logic [4:0]        buf_address,
    input  logic [31:0]       buf_rdata,
    output logic              mem_request,
    input  logic              mem_ack,
    output logic [MEM_AW-1:0] mem_address,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_WR_FETCH,
        S_WR_LOAD,
        S_WR_MEM,
        S_DONE,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [14:0] cnt;
    logic        op_all;
    logic [9:0]  op_sector;
    logic        last_word;

    // Word offset inside the FlashRAM image for erase word c.
    function automatic logic [14:0] erase_off(
        input logic        all,
        input logic [2:0]  sec3,
        input logic [14:0] c
    );
        return all ? c : {sec3, c[11:0]};
    endfunction

    // Erase length depends on scope; page writes are always 32 words.
    always_comb begin
        last_word = (cnt[4:0] == 5'd31);
        if (state == S_ERASE)
            last_word = op_all ? (cnt == 15'h7FFF)
                               : (cnt[11:0] == 12'hFFF);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (operation_pending) begin
                    if (!enable)
                        state_next = S_DONE;
                    else if (write_or_erase)
                        state_next = S_ERASE;
                    else
                        state_next = S_WR_FETCH;
                end
            end
            S_ERASE: begin
                if (mem_ack && last_word)
                    state_next = S_DONE;
            end
            S_WR_FETCH: state_next = S_WR_LOAD;
            S_WR_LOAD:  state_next = S_WR_MEM;
            S_WR_MEM: begin
                if (mem_ack)
                    state_next = last_word ? S_DONE : S_WR_FETCH;
            end
            S_DONE:  state_next = S_HOLD;
            // HOLD swallows the pending flag the front-end still shows
            // during the cycle after done.
            S_HOLD:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_all      <= 1'b0;
            op_sector   <= '0;
            mem_request <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: begin
                    if (operation_pending) begin
                        op_all    <= sector_or_all;
                        op_sector <= sector;
                        cnt       <= '0;
                        if (enable && write_or_erase) begin
                            mem_request <= 1'b1;
                            mem_wdata   <= 32'hFFFF_FFFF;
                            mem_address <= FLASH_BASE + MEM_AW'(
                                erase_off(sector_or_all,
                                          sector[9:7], 15'd0));
                        end
                    end
                end
                S_ERASE: begin
                    // Request stays up across acks so erase streams
                    // one word per accepted cycle.
                    if (mem_ack) begin
                        if (last_word) begin
                            mem_request <= 1'b0;
                        end else begin
                            cnt         <= cnt + 15'd1;
                            mem_address <= FLASH_BASE + MEM_AW'(
                                erase_off(op_all, op_sector[9:7],
                                          cnt + 15'd1));
                        end
                    end
                end
                S_WR_LOAD: begin
                    mem_request <= 1'b1;
                    mem_wdata   <= buf_rdata;
                    mem_address <= FLASH_BASE +
                                   MEM_AW'({op_sector, cnt[4:0]});
                end
                S_WR_MEM: begin
                    if (mem_ack) begin
                        mem_request <= 1'b0;
                        if (!last_word)
                            cnt <= cnt + 15'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign operation_done = (state == S_DONE);
    assign buf_address    = cnt[4:0];

endmodule

// File: tb/tb_n64_flashram_executor.sv
// Self-checking bench for n64_flashram_executor: randomized ack timing and
// op fields, writes collected and compared with an arithmetic reference.
`timescale 1ns/1ps
module tb_n64_flashram_executor;

    localparam logic [23:0] BASE = 24'h0FC000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        operation_pending;
    logic        write_or_erase;
    logic        sector_or_all;
    logic [9:0]  sector;
    logic        operation_done;
    logic [4:0]  buf_address;
    logic [31:0] buf_rdata;
    logic        mem_request;
    logic        mem_ack;
    logic [23:0] mem_address;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    n64_flashram_executor dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .operation_pending (operation_pending),
        .write_or_erase    (write_or_erase),
        .sector_or_all     (sector_or_all),
        .sector            (sector),
        .operation_done    (operation_done),
        .buf_address       (buf_address),
        .buf_rdata         (buf_rdata),
        .mem_request       (mem_request),
        .mem_ack           (mem_ack),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata)
    );

    // Page buffer with one-cycle read latency.
    logic [31:0] buffer [32];
    always @(posedge clk) buf_rdata <= buffer[buf_address];

    typedef struct packed {
        logic [23:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t wq[$];
    int  checks = 0;
    int  fails = 0;
    int  done_cnt, done_edge, last_acc, stall_sum;
    int  unstable, dropped, req_seen, edges;
    bit  timeout, aborted;

    // mode 0: ack tied high, 1: ack one cycle after request,
    // 2: mostly immediate with occasional 1-5 cycle stalls.
    function automatic int pick(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(1, 5));
        return 0;
    endfunction

    // Drive one op, act as memory, record every accepted write.
    task automatic run_op(input logic erase, input logic all,
                          input logic [9:0] sec, input int mode,
                          input logic en, input bit scramble,
                          input int abort_at, input int budget);
        int          waited, target, after;
        bit          prev_stall;
        logic [23:0] pa;
        logic [31:0] pd;
        wq.delete();
        done_cnt = 0; done_edge = -1; last_acc = -1; stall_sum = 0;
        unstable = 0; dropped = 0; req_seen = 0;
        timeout = 0; aborted = 0;
        @(negedge clk);
        operation_pending = 1'b1;
        write_or_erase = erase;
        sector_or_all = all;
        sector = sec;
        enable = en;
        mem_ack = (mode == 0);
        edges = 0; waited = 0; target = pick(mode);
        prev_stall = 0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            edges++;
            if (operation_done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = edges;
            end
            if (prev_stall && !mem_request) dropped++;
            if (prev_stall && mem_request &&
                (mem_address !== pa || mem_wdata !== pd)) unstable++;
            prev_stall = 0;
            if (mem_request) begin
                req_seen++;
                if (abort_at >= 0 && wq.size() == abort_at) begin
                    reset = 1'b1;
                    mem_ack = 1'b0;
                    operation_pending = 1'b0;
                    aborted = 1;
                    return;
                end
                if (waited >= target) begin
                    mem_ack = 1'b1;
                    wq.push_back({mem_address, mem_wdata});
                    stall_sum += target;
                    last_acc = edges;
                    waited = 0;
                    target = pick(mode);
                end else begin
                    mem_ack = 1'b0;
                    waited++;
                    prev_stall = 1;
                    pa = mem_address;
                    pd = mem_wdata;
                end
            end else begin
                mem_ack = (mode == 0);
            end
            if (scramble) begin
                sector = 10'($urandom);
                write_or_erase = 1'($urandom);
                sector_or_all = 1'($urandom);
                enable = 1'($urandom);
            end
            if (done_edge >= 0) begin
                after = edges - done_edge;
                if (after == 2) operation_pending = 1'b0;
                if (after >= 5) break;
            end
            if (edges >= budget) begin
                timeout = 1;
                operation_pending = 1'b0;
                break;
            end
        end
        mem_ack = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (operation_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", operation_done); end
        checks++; if (buf_address !== 5'd0) begin fails++; $display("FAIL rst_buf_address: got %h want 0", buf_address); end
        checks++; if (mem_request !== 1'b0) begin fails++; $display("FAIL rst_mem_request: got %b want 0", mem_request); end
        checks++; if (mem_address !== 24'd0) begin fails++; $display("FAIL rst_mem_address: got %h want 0", mem_address); end
        checks++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_page_write(input string tag, input logic [9:0] sec,
                                   input int mode, input bit scramble);
        int  bad;
        wr_t e;
        run_op(1'b0, 1'b0, sec, mode, 1'b1, scramble, -1, 2000);
        bad = -1;
        for (int i = 0; i < wq.size() && i < 32; i++) begin
            e = {BASE + 24'(sec) * 24'd32 + 24'(i), buffer[i]};
            if (bad < 0 && wq[i] !== e) bad = i;
        end
        checks++; if (timeout) begin fails++; $display("FAIL %s_timeout: got timeout want done", tag); end
        checks++; if (wq.size() != 32) begin fails++; $display("FAIL %s_count: got %0d want 32", tag, wq.size()); end
        checks++; if (bad != -1) begin fails++; $display("FAIL %s_data: got first bad word %0d (%h) want none", tag, bad, wq[bad]); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL %s_done_pulses: got %0d want 1", tag, done_cnt); end
        checks++; if (done_edge != 1 + 96 + stall_sum) begin fails++; $display("FAIL %s_latency: got %0d want %0d", tag, done_edge, 1 + 96 + stall_sum); end
        checks++; if (unstable != 0 || dropped != 0) begin fails++; $display("FAIL %s_handshake: got unstable %0d dropped %0d want 0 0", tag, unstable, dropped); end
        checks++; if (mem_request !== 1'b0) begin fails++; $display("FAIL %s_idle_req: got %b want 0", tag, mem_request); end
    endtask

    task automatic test_page_write_basic();
        foreach (buffer[i]) buffer[i] = 32'hA000_0000 + 32'(i);
        test_page_write("wr_basic", 10'h005, 1, 0);
    endtask

    task automatic test_sector_change();
        foreach (buffer[i]) buffer[i] = $urandom;
        test_page_write("wr_scramble", 10'($urandom), 2, 1);
    endtask

    task automatic test_sector_erase();
        int          bad;
        logic [9:0]  sec;
        logic [23:0] ea;
        sec = 10'h1C3;
        run_op(1'b1, 1'b0, sec, 0, 1'b1, 0, -1, 6000);
        bad = -1;
        foreach (wq[i]) begin
            ea = BASE + 24'(sec[9:7]) * 24'd4096 + 24'(i);
            if (bad < 0 && wq[i] !== {ea, 32'hFFFF_FFFF}) bad = i;
        end
        checks++; if (timeout) begin fails++; $display("FAIL sec_timeout: got timeout want done"); end
        checks++; if (wq.size() != 4096) begin fails++; $display("FAIL sec_count: got %0d want 4096", wq.size()); end
        checks++; if (bad != -1) begin fails++; $display("FAIL sec_data: got first bad word %0d (%h) want none", bad, wq[bad]); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL sec_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (done_edge != last_acc + 1) begin fails++; $display("FAIL sec_done_after_ack: got %0d want %0d", done_edge, last_acc + 1); end
        checks++; if (done_edge != 1 + 4096) begin fails++; $display("FAIL sec_back_to_back: got %0d want %0d", done_edge, 4097); end
    endtask

    task automatic test_chip_erase();
        int bad;
        run_op(1'b1, 1'b1, 10'($urandom), 2, 1'b1, 0, -1, 120000);
        bad = -1;
        foreach (wq[i])
            if (bad < 0 && wq[i] !== {BASE + 24'(i), 32'hFFFF_FFFF}) bad = i;
        checks++; if (timeout) begin fails++; $display("FAIL chip_timeout: got timeout want done"); end
        checks++; if (wq.size() != 32768) begin fails++; $display("FAIL chip_count: got %0d want 32768", wq.size()); end
        checks++; if (bad != -1) begin fails++; $display("FAIL chip_data: got first bad word %0d (%h) want none", bad, wq[bad]); end
        checks++; if (unstable != 0 || dropped != 0) begin fails++; $display("FAIL chip_stall_stable: got unstable %0d dropped %0d want 0 0", unstable, dropped); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL chip_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (done_edge != 1 + 32768 + stall_sum) begin fails++; $display("FAIL chip_latency: got %0d want %0d", done_edge, 1 + 32768 + stall_sum); end
    endtask

    task automatic test_disabled();
        run_op(1'b0, 1'b0, 10'($urandom), 1, 1'b0, 0, -1, 100);
        checks++; if (timeout) begin fails++; $display("FAIL dis_timeout: got timeout want done"); end
        checks++; if (req_seen != 0) begin fails++; $display("FAIL dis_no_request: got %0d request cycles want 0", req_seen); end
        checks++; if (done_edge != 1) begin fails++; $display("FAIL dis_latency: got %0d want 1", done_edge); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL dis_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_erase();
        int n;
        run_op(1'b1, 1'b0, 10'($urandom), 0, 1'b1, 0, 9, 100);
        checks++; if (!aborted) begin fails++; $display("FAIL abort_reached: got no 10th word want reached"); end
        checks++; if (wq.size() != 9) begin fails++; $display("FAIL abort_words: got %0d want 9", wq.size()); end
        @(negedge clk);
        checks++; if (mem_request !== 1'b0) begin fails++; $display("FAIL abort_req_drop: got %b want 0", mem_request); end
        reset = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (operation_done) n++;
        end
        checks++; if (n != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", n); end
        foreach (buffer[i]) buffer[i] = $urandom;
        test_page_write("wr_after_rst", 10'($urandom), 2, 0);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        operation_pending = 1'b0;
        write_or_erase = 1'b0;
        sector_or_all = 1'b0;
        sector = '0;
        mem_ack = 1'b0;
        foreach (buffer[i]) buffer[i] = '0;
        test_reset();
        test_page_write_basic();
        test_sector_erase();
        test_disabled();
        test_reset_mid_erase();
        test_sector_change();
        test_chip_erase();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
